// File: rtl/model_test_mac_pipe.sv
// model_test_mac_pipe: pipelined signed multiply / multiply-accumulate with
// valid/ready flow control. Define MODEL_TEST_MAC_SAT_EN to make every
// accumulator add saturate and to report out_ovf. Without it, sums wrap and
// out_ovf is tied to 0.
module model_test_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 12,
    parameter int din1_WIDTH = 6,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_acc,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  out_ovf
);
    localparam int PW = din0_WIDTH + din1_WIDTH;

    logic                        adv;
    logic signed [PW-1:0]        prod;
    logic                        arr_v;
    logic                        arr_a;
    logic                        arr_l;
    logic signed [PW-1:0]        arr_p;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        acc_first;

    // Parameter sanity: an illegal configuration elaborates this empty block,
    // which then shows up by name in the hierarchy. ID has no functional effect.
    if (NUM_STAGE < 1 || NUM_STAGE > 8 || ACC_WIDTH < PW || ID < 0) begin : g_bad_cfg
    end

    // The whole pipe moves together; it only holds when a result is waiting
    // and downstream is not taking it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Exact signed product: both operands are sign-extended to the full product width.
    assign prod  = PW'($signed(din0)) * PW'($signed(din1));
    assign p_ext = ACC_WIDTH'(arr_p);

    if (NUM_STAGE > 1) begin : g_pipe
        localparam int DEPTH = NUM_STAGE - 1;

        logic [DEPTH-1:0]     st_v;
        logic [DEPTH-1:0]     st_a;
        logic [DEPTH-1:0]     st_l;
        logic signed [PW-1:0] st_p [DEPTH];

        // Stage valid bits shift forward on every advance; reset empties the pipe.
        always_ff @(posedge clk) begin
            // NOTE: non-blocking assignments so each stage takes its neighbour's pre-edge value.
            if (reset) begin
                st_v <= '0;
            end else if (adv) begin
                st_v[0] <= in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    st_v[i] <= st_v[i-1];
                end
            end
        end

        // Stage payloads shift alongside their valid bits.
        always_ff @(posedge clk) begin
            // NOTE: payload registers carry no reset; the matching stage valid qualifies them.
            if (adv) begin
                st_a[0] <= in_acc;
                st_l[0] <= in_last;
                st_p[0] <= prod;
                for (int i = 1; i < DEPTH; i++) begin
                    st_a[i] <= st_a[i-1];
                    st_l[i] <= st_l[i-1];
                    st_p[i] <= st_p[i-1];
                end
            end
        end

        assign arr_v = st_v[DEPTH-1];
        assign arr_a = st_a[DEPTH-1];
        assign arr_l = st_l[DEPTH-1];
        assign arr_p = st_p[DEPTH-1];
    end else begin : g_direct
        assign arr_v = in_valid;
        assign arr_a = in_acc;
        assign arr_l = in_last;
        assign arr_p = prod;
    end

    // Starting value of the running sum: zero on the first beat of a sum.
    always_comb begin
        // NOTE: default assigned first so no path through this block leaves base unassigned (no latch).
        base = acc;
        if (acc_first) begin
            base = '0;
        end
    end

`ifdef MODEL_TEST_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] wide;
    logic                      sat_evt;
    logic                      acc_ovf;
    logic                      ovf_run;

    // One extra bit exposes the true sign of the add; clamp when it disagrees
    // with the truncated result.
    always_comb begin
        wide    = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(p_ext);
        sat_evt = (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]);
        sum     = wide[ACC_WIDTH-1:0];
        if (sat_evt) begin
            sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    assign ovf_run = (!acc_first && acc_ovf) || sat_evt;

    // Sticky overflow for the sum in progress; published with the closing beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_ovf <= 1'b0;
            out_ovf <= 1'b0;
        end else if (adv && arr_v) begin
            if (!arr_a) begin
                out_ovf <= 1'b0;
            end else if (!arr_l) begin
                acc_ovf <= ovf_run;
            end else begin
                out_ovf <= ovf_run;
            end
        end
    end
`else
    assign sum     = base + p_ext;
    assign out_ovf = 1'b0;
`endif

    // Output / accumulator register: takes the arriving beat whenever the output slot frees.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc       <= '0;
            acc_first <= 1'b1;
        end else if (adv) begin
            if (!arr_v) begin
                out_valid <= 1'b0;
            end else if (!arr_a) begin
                dout      <= p_ext;
                out_valid <= 1'b1;
                acc_first <= 1'b1;
            end else if (!arr_l) begin
                acc       <= sum;
                acc_first <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                dout      <= sum;
                out_valid <= 1'b1;
                acc_first <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_model_test_mac_pipe.sv
// Testbench for model_test_mac_pipe: two instances (24-bit and 18-bit
// accumulators) share all inputs; each has an expectation queue filled by a
// plain-integer reference model and drained by its own output monitor.
module tb_model_test_mac_pipe;
    localparam int NS   = 3;
    localparam int AW_A = 24;
    localparam int AW_B = 18;
`ifdef MODEL_TEST_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_acc = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b1;
    logic [11:0]       din0 = '0;
    logic [5:0]        din1 = '0;
    logic              in_ready_a, in_ready_b;
    logic              out_valid_a, out_valid_b;
    logic              ovf_a, ovf_b;
    logic [AW_A-1:0]   dout_a;
    logic [AW_B-1:0]   dout_b;

    typedef struct {
        longint dout;
        bit     ovf;
        int     cyc;
        bit     lat_chk;
    } exp_t;

    typedef struct {
        longint sum;
        bit     first;
        bit     ovf;
    } run_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;
    run_t run_a;
    run_t run_b;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   lat_chk_en = 1'b1;
    bit   rand_ready = 1'b0;

    model_test_mac_pipe #(.ID(1), .NUM_STAGE(NS), .din0_WIDTH(12), .din1_WIDTH(6), .ACC_WIDTH(AW_A)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .din0(din0), .din1(din1), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .dout(dout_a), .out_ovf(ovf_a)
    );

    model_test_mac_pipe #(.ID(2), .NUM_STAGE(NS), .din0_WIDTH(12), .din1_WIDTH(6), .ACC_WIDTH(AW_B)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .din0(din0), .din1(din1), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .dout(dout_b), .out_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not occur within its bound (cycle %0d)", name, cyc);
    endtask

    // Two's-complement wrap of an integer into w bits.
    function automatic longint wrap(input longint v, input int w);
        longint one = 1;
        longint m;
        m = v & ((one << w) - 1);
        if (m >= (one << (w - 1))) m = m - (one << w);
        return m;
    endfunction

    // Reference behaviour of one accepted beat for an accumulator of width w.
    function automatic void model_beat(input int w, input longint p, input bit acc, input bit last,
                                       inout run_t r, output bit emit, output longint val, output bit ovf);
        longint one = 1;
        longint hi = (one << (w - 1)) - 1;
        longint lo = -(one << (w - 1));
        longint raw;
        bit     evt = 1'b0;
        emit = 1'b0;
        val  = 0;
        ovf  = 1'b0;
        if (!acc) begin
            emit    = 1'b1;
            val     = wrap(p, w);
            r.first = 1'b1;
        end else begin
            raw = (r.first ? 0 : r.sum) + p;
            if (SAT) begin
                if (raw > hi) begin raw = hi; evt = 1'b1; end
                else if (raw < lo) begin raw = lo; evt = 1'b1; end
            end else begin
                raw = wrap(raw, w);
            end
            ovf = (r.first ? 1'b0 : r.ovf) | evt;
            if (last) begin
                emit    = 1'b1;
                val     = raw;
                r.first = 1'b1;
            end else begin
                r.sum   = raw;
                r.ovf   = ovf;
                r.first = 1'b0;
                ovf     = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        run_a = '{0, 1'b1, 1'b0};
        run_b = '{0, 1'b1, 1'b0};
    endtask

    // Advance to just after the next rising edge; optionally randomise back-pressure.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Present one beat until accepted, then record its expected result(s).
    task automatic send(input int a, input int b, input bit acc, input bit last, output int tries);
        longint p;
        bit     emit;
        longint val;
        bit     ovf;
        din0     = 12'(a);
        din1     = 6'(b);
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        tries    = 0;
        forever begin
            @(negedge clk);
            tries++;
            if (in_ready_a) break;
            if (tries > 200) begin
                fail_now("send_accept");
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("in_ready_b", in_ready_b, 1);
        p = longint'(a) * longint'(b);
        model_beat(AW_A, p, acc, last, run_a, emit, val, ovf);
        if (emit) q_a.push_back('{val, ovf, cyc, lat_chk_en});
        model_beat(AW_B, p, acc, last, run_b, emit, val, ovf);
        if (emit) q_b.push_back('{val, ovf, cyc, lat_chk_en});
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int pick(input int w);
        int lo = -(1 << (w - 1));
        int hi = (1 << (w - 1)) - 1;
        case ($urandom_range(0, 5))
            0:       return lo;
            1:       return hi;
            default: return int'($urandom_range(0, (1 << w) - 1)) + lo;
        endcase
    endfunction

    // Output monitor for the 24-bit instance.
    always @(negedge clk) begin
        if (!reset && out_valid_a === 1'b1 && out_ready) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_a_unexpected: got dout=%0d, expected no output (cycle %0d)", $signed(dout_a), cyc);
            end else begin
                mon_a = q_a.pop_front();
                check("dout_a", $signed(dout_a), mon_a.dout);
                check("ovf_a", ovf_a, longint'(mon_a.ovf));
                if (mon_a.lat_chk) check("latency_a", cyc - mon_a.cyc, NS);
            end
        end
    end

    // Output monitor for the 18-bit instance.
    always @(negedge clk) begin
        if (!reset && out_valid_b === 1'b1 && out_ready) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_b_unexpected: got dout=%0d, expected no output (cycle %0d)", $signed(dout_b), cyc);
            end else begin
                mon_b = q_b.pop_front();
                check("dout_b", $signed(dout_b), mon_b.dout);
                check("ovf_b", ovf_b, longint'(mon_b.ovf));
                if (mon_b.lat_chk) check("latency_b", cyc - mon_b.cyc, NS);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tries;
        int w;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_dout_a", $signed(dout_a), 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_out_valid_b", out_valid_b, 0);
        check("rst_dout_b", $signed(dout_b), 0);
        check("rst_in_ready", in_ready_a, 1);
        tick();
        reset = 1'b0;
        tick();

        // Most negative operands, plain multiply.
        send(-2048, -32, 1'b0, 1'b0, tries);
        idle(6);

        // Ten streaming plain beats; never back-pressured.
        for (int i = 0; i < 10; i++) begin
            send(i, 3, 1'b0, 1'b0, tries);
            check("stream_in_ready", tries, 1);
        end
        idle(6);

        // Four-beat dot product.
        send(100, 2, 1'b1, 1'b0, tries);
        send(-50, 2, 1'b1, 1'b0, tries);
        send(7, -1, 1'b1, 1'b0, tries);
        send(1, 5, 1'b1, 1'b1, tries);
        idle(6);

        // Output stall with three beats in flight.
        lat_chk_en = 1'b0;
        out_ready  = 1'b0;
        send(7, -3, 1'b0, 1'b0, tries);
        send(-100, 20, 1'b0, 1'b0, tries);
        send(2047, 31, 1'b0, 1'b0, tries);
        @(negedge clk);
        w = 0;
        while (out_valid_a !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) fail_now("stall_out_valid");
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", in_ready_a, 0);
            check("stall_out_valid", out_valid_a, 1);
            check("stall_dout", $signed(dout_a), -21);
            if (k < 4) @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        idle(8);
        lat_chk_en = 1'b1;

        // Reset with two beats accumulated and a third in flight.
        send(10, 10, 1'b1, 1'b0, tries);
        send(-3, 4, 1'b1, 1'b0, tries);
        idle(2);
        send(9, 9, 1'b1, 1'b0, tries);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_out_valid", out_valid_a, 0);
        check("midrst_dout", $signed(dout_a), 0);
        check("midrst_ovf", ovf_a, 0);
        tick();
        send(5, 5, 1'b1, 1'b1, tries);
        idle(6);

        // Long sum that overflows the 18-bit accumulator.
        for (int i = 1; i <= 20; i++) begin
            send(2047, 31, 1'b1, (i == 20), tries);
        end
        idle(6);

        // Randomised beats with random back-pressure.
        lat_chk_en = 1'b0;
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(pick(12), pick(6), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), tries);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < 50) begin
            tick();
            w++;
        end
        check("drain_q_a", q_a.size(), 0);
        check("drain_q_b", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
